// File: rtl/sd_cmd_resp_rx_pkg.sv
// sd_cmd_resp_rx_pkg: shared SD constants, receiver state encodings and CRC7 step
package sd_cmd_resp_rx_pkg;
    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam int         SD_RESP48_BITS = 48;
    localparam int         SD_NCR_MAX     = 64;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        return {crc[5:0], 1'b0} ^ ((crc[6] ^ b) ? CRC7_POLY : 7'h00);
    endfunction
endpackage

// File: rtl/sd_cmd_resp_rx_if.sv
// sd_cmd_resp_rx_if: host-side bundle between the host FSM and the response receiver
interface sd_cmd_resp_rx_if;
    logic        sample_en;
    logic        cmd_in;
    logic        start;
    logic        crc_check_en;
    logic        busy;
    logic        done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        crc_err;
    logic        tx_err;
    logic        end_err;
    logic        timeout;
    modport master (output sample_en, cmd_in, start, crc_check_en,
                    input  busy, done, resp_index, resp_arg, crc_err, tx_err, end_err, timeout);
    modport slave  (input  sample_en, cmd_in, start, crc_check_en,
                    output busy, done, resp_index, resp_arg, crc_err, tx_err, end_err, timeout);
endinterface

// File: rtl/sd_cmd_resp_rx_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1, init 0), shared with the command sender
module sd_crc7
    import sd_cmd_resp_rx_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [6:0] o_crc
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)   o_crc <= '0;
        else if (i_clr) o_crc <= '0;
        else if (i_en)  o_crc <= crc7_step(o_crc, i_din);
endmodule

// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx: receives a 48-bit SD command response and reports index, argument and error flags
module sd_cmd_resp_rx
    import sd_cmd_resp_rx_pkg::*;
#(
    parameter int NCR_MAX   = SD_NCR_MAX,
    parameter int RESP_BITS = SD_RESP48_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    sd_cmd_resp_rx_if.slave   bus
);
    logic [1:0]           r_state;
    logic [6:0]           r_ncr_cnt;
    logic [5:0]           r_bit_cnt;
    logic [RESP_BITS-3:0] r_sh;
    logic                 r_chk;
    logic [RESP_BITS-2:0] w_sh;
    logic [6:0]           w_crc;
    logic                 w_crc_en;
    logic                 w_arm;
    assign w_sh     = {r_sh, bus.cmd_in};
    assign w_arm    = r_state == ST_IDLE && bus.start;
    // start bit and bits 46..8 feed the CRC; the CRC field and end bit do not
    assign w_crc_en = bus.sample_en && ((r_state == ST_WAIT && !bus.cmd_in) ||
                                        (r_state == ST_SHIFT && r_bit_cnt >= 6'd8));
    assign bus.busy = r_state == ST_WAIT || r_state == ST_SHIFT;
    assign bus.done = r_state == ST_DONE;
    sd_crc7 u_crc (
        .clk   (clk),
        .resetn(resetn),
        .i_clr (w_arm),
        .i_en  (w_crc_en),
        .i_din (bus.cmd_in),
        .o_crc (w_crc)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_ncr_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_sh           <= '0;
            r_chk          <= 1'b0;
            bus.resp_index <= '0;
            bus.resp_arg   <= '0;
            bus.crc_err    <= 1'b0;
            bus.tx_err     <= 1'b0;
            bus.end_err    <= 1'b0;
            bus.timeout    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_state     <= ST_WAIT;
                r_ncr_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_chk       <= bus.crc_check_en;
                bus.crc_err <= 1'b0;
                bus.tx_err  <= 1'b0;
                bus.end_err <= 1'b0;
                bus.timeout <= 1'b0;
            end
        end else if (r_state == ST_WAIT) begin
            if (bus.sample_en && !bus.cmd_in) begin
                r_state   <= ST_SHIFT;
                r_bit_cnt <= 6'(RESP_BITS - 2);
            end else if (bus.sample_en) begin
                r_ncr_cnt <= r_ncr_cnt + 7'd1;
                if (r_ncr_cnt == 7'(NCR_MAX - 1)) begin
                    r_state     <= ST_DONE;
                    bus.timeout <= 1'b1;
                end
            end
        end else if (r_state == ST_SHIFT) begin
            if (bus.sample_en) begin
                r_sh      <= w_sh[RESP_BITS-3:0];
                r_bit_cnt <= r_bit_cnt - 6'd1;
                if (r_bit_cnt == 6'd0) begin
                    r_state        <= ST_DONE;
                    bus.resp_index <= w_sh[45:40];
                    bus.resp_arg   <= w_sh[39:8];
                    bus.tx_err     <= w_sh[46];
                    bus.end_err    <= !w_sh[0];
                    bus.crc_err    <= r_chk && (w_crc != w_sh[7:1]);
                end
            end
        end else begin
            r_state <= ST_IDLE;
        end
    end
endmodule
